flexbex_ibex_multdiv_slow: RTL and testbench

Iterative 32-bit multiplier/divider for the flexbex ibex execute stage, implementing RV32M (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It owns no adder of its own. It drives the ALU's shared 33-bit multdiv adder port (operand A/B, enable) and consumes the ALU's 34-bit extended adder result. It issues one adder operation per cycle and has a fixed latency of 37 cycles.

---
 rtl/flexbex_ibex_multdiv_slow.sv | 163 ++++++++++++++++
 tb/tb_flexbex_ibex_multdiv_slow.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/flexbex_ibex_multdiv_slow.sv
// Iterative RV32M multiplier/divider that borrows the ALU's shared 33-bit adder.
// One adder operation per cycle; every operation takes exactly 37 cycles.
module flexbex_ibex_multdiv_slow (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [33:0] alu_adder_ext_i,
  output logic [32:0] alu_operand_a_o,
  output logic [32:0] alu_operand_b_o,
  output logic        multdiv_en_o,
  output logic [31:0] result_o,
  output logic        valid_o
);

  typedef enum logic [2:0] {
    IDLE, ABS_A, ABS_B, COMP, SIGN_LO, SIGN_HI, FINISH
  } state_e;

  state_e      state_q;
  logic [2:0]  op_q;
  logic [31:0] abs_a_q, abs_b_q, hi_q, lo_q;
  logic        neg_quot_q, neg_rem_q, carry_q;
  logic [5:0]  cnt_q;

  logic [31:0] sum, sh;
  logic        carry, acc, is_div, neg_a, neg_b, unused_lsb;

  function automatic logic sa_of(input logic [2:0] op);
    return (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
  endfunction

  function automatic logic sb_of(input logic [2:0] op);
    return (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
  endfunction

  assign sum        = alu_adder_ext_i[32:1];
  assign carry      = alu_adder_ext_i[33];
  assign unused_lsb = alu_adder_ext_i[0];
  assign is_div     = op_q[2];
  // hi/lo double as rem/quo during division; sh is the shifted partial remainder
  assign sh         = {hi_q[30:0], lo_q[31]};
  assign acc        = hi_q[31] | carry;
  assign neg_a      = sa_of(op_q) & abs_a_q[31];
  assign neg_b      = sb_of(op_q) & abs_b_q[31];

  always_comb begin
    alu_operand_a_o = '0;
    alu_operand_b_o = '0;
    multdiv_en_o    = 1'b0;
    case (state_q)
      ABS_A: begin
        multdiv_en_o    = 1'b1;
        alu_operand_a_o = neg_a ? {~abs_a_q, 1'b1} : {abs_a_q, 1'b0};
        alu_operand_b_o = {32'b0, neg_a};
      end
      ABS_B: begin
        multdiv_en_o    = 1'b1;
        alu_operand_a_o = neg_b ? {~abs_b_q, 1'b1} : {abs_b_q, 1'b0};
        alu_operand_b_o = {32'b0, neg_b};
      end
      COMP: begin
        multdiv_en_o = 1'b1;
        if (is_div) begin
          alu_operand_a_o = {sh, 1'b1};
          alu_operand_b_o = {~abs_b_q, 1'b1};
        end else begin
          alu_operand_a_o = {hi_q, 1'b0};
          alu_operand_b_o = {(lo_q[0] ? abs_a_q : 32'b0), 1'b0};
        end
      end
      SIGN_LO: begin
        multdiv_en_o = 1'b1;
        if (neg_quot_q) begin
          alu_operand_a_o = {~lo_q, 1'b1};
          alu_operand_b_o = {32'b0, 1'b1};
        end
      end
      SIGN_HI: begin
        multdiv_en_o = 1'b1;
        if (is_div && neg_rem_q) begin
          alu_operand_a_o = {~hi_q, 1'b1};
          alu_operand_b_o = {32'b0, 1'b1};
        end else if (!is_div && neg_quot_q) begin
          alu_operand_a_o = {~hi_q, carry_q};
          alu_operand_b_o = {32'b0, carry_q};
        end
      end
      default: ;
    endcase
  end

  assign valid_o  = (state_q == FINISH);
  assign result_o = (state_q != FINISH) ? 32'b0 :
                    is_div ? (op_q[1] ? hi_q : lo_q) :
                    ((op_q == 3'd0) ? lo_q : hi_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      op_q       <= '0;
      abs_a_q    <= '0;
      abs_b_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
    end else if (state_q != IDLE && !en_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (en_i) begin
          op_q       <= op_i;
          abs_a_q    <= op_a_i;
          abs_b_q    <= op_b_i;
          // a zero divisor must leave the all-ones quotient unnegated
          neg_quot_q <= ((sa_of(op_i) & op_a_i[31]) ^ (sb_of(op_i) & op_b_i[31])) &
                        ~(op_i[2] & ~op_i[1] & (op_b_i == 32'b0));
          neg_rem_q  <= sa_of(op_i) & op_a_i[31];
          state_q    <= ABS_A;
        end
        ABS_A: begin
          abs_a_q <= sum;
          state_q <= ABS_B;
        end
        ABS_B: begin
          abs_b_q <= sum;
          hi_q    <= '0;
          lo_q    <= is_div ? abs_a_q : sum;
          cnt_q   <= '0;
          state_q <= COMP;
        end
        COMP: begin
          if (is_div) begin
            hi_q <= acc ? sum : sh;
            lo_q <= {lo_q[30:0], acc};
          end else begin
            hi_q <= {carry, sum[31:1]};
            lo_q <= {sum[0], lo_q[31:1]};
          end
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_q <= SIGN_LO;
        end
        SIGN_LO: begin
          if (neg_quot_q) lo_q <= sum;
          carry_q <= neg_quot_q & carry;
          state_q <= SIGN_HI;
        end
        SIGN_HI: begin
          if (is_div ? neg_rem_q : neg_quot_q) hi_q <= sum;
          state_q <= FINISH;
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flexbex_ibex_multdiv_slow.sv
// Self-checking bench for flexbex_ibex_multdiv_slow: directed table, abort/reset
// sequences and a random scoreboard against a 64-bit arithmetic reference.
module tb_flexbex_ibex_multdiv_slow;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [33:0] alu_ext;
  logic [32:0] alu_a, alu_b;
  logic        multdiv_en, valid;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  flexbex_ibex_multdiv_slow dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .op_i(op), .op_a_i(op_a), .op_b_i(op_b),
    .alu_adder_ext_i(alu_ext), .alu_operand_a_o(alu_a), .alu_operand_b_o(alu_b),
    .multdiv_en_o(multdiv_en), .result_o(result), .valid_o(valid)
  );

  // The ALU's extended adder: plain 34-bit sum of the two 33-bit operands
  assign alu_ext = {1'b0, alu_a} + {1'b0, alu_b};

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Runs one request; reports the result, the cycle valid first rose, how many
  // cycles had valid high, and how many cycles had multdiv_en outside 1..36.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] res, output int lat,
                               output int valid_cnt, output int en_bad);
    @(negedge clk);
    op = o; op_a = a; op_b = b; en = 1'b1;
    @(posedge clk);
    lat = -1; valid_cnt = 0; en_bad = 0; res = '0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (c == 2) begin
        op_a = ~a; op_b = ~b; op = ~o;
      end
      if (multdiv_en !== ((c >= 1) && (c <= 36))) en_bad++;
      if (valid === 1'b1) begin
        valid_cnt++;
        if (lat < 0) begin
          lat = c; res = result; en = 1'b0;
        end
      end
      if (lat >= 0 && c > lat) break;
    end
    en = 1'b0;
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, za, zb, p;
    logic        ovf;
    sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
    za = {32'b0, a};       zb = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = za * zb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * zb; return p[63:32]; end
      3'd3: begin p = za * zb; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs[16];
    logic [31:0] res;
    int          lat, vcnt, ebad, seen;
    string       tag;

    vecs[0]  = '{3'd0, 32'd7,          32'd6,          32'h0000_002A};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,          32'd14};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,          32'd2};
    vecs[8]  = '{3'd4, 32'd5,          32'd0,          32'hFFFF_FFFF};
    vecs[9]  = '{3'd6, 32'd5,          32'd0,          32'd5};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0};
    vecs[12] = '{3'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    vecs[13] = '{3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000};
    vecs[14] = '{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF};
    vecs[15] = '{3'd3, 32'h8000_0000,  32'd2,          32'h1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_valid", 64'(valid), 64'd0);
    checkOutput("reset_en", 64'(multdiv_en), 64'd0);
    checkOutput("reset_result", 64'(result), 64'd0);
    checkOutput("reset_operands", {31'b0, alu_a, alu_b} >> 2, 64'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, vcnt, ebad);
      tag = $sformatf("vec%0d_op%0d", i, vecs[i].op);
      checkOutput({tag, "_result"}, 64'(res), 64'(vecs[i].exp));
      checkOutput({tag, "_latency"}, 64'(lat), 64'd37);
      checkOutput({tag, "_valid_cycles"}, 64'(vcnt), 64'd1);
      checkOutput({tag, "_en_window"}, 64'(ebad), 64'd0);
    end

    // Abort: drop en at cycle 10, expect IDLE next cycle and no completion
    @(negedge clk);
    op = 3'd5; op_a = 32'd1000; op_b = 32'd3; en = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checkOutput("abort_en_low", 64'(multdiv_en), 64'd0);
    checkOutput("abort_operands", {31'b0, alu_a, alu_b} >> 2, 64'd0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (valid === 1'b1) seen++;
      @(negedge clk);
    end
    checkOutput("abort_no_valid", 64'(seen), 64'd0);

    // Reset at cycle 20 of a new operation
    op = 3'd1; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0; en = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) @(negedge clk);
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    checkOutput("rst_valid", 64'(valid), 64'd0);
    checkOutput("rst_en", 64'(multdiv_en), 64'd0);
    checkOutput("rst_result", 64'(result), 64'd0);
    checkOutput("rst_operands", {31'b0, alu_a, alu_b} >> 2, 64'd0);
    rst = 1'b0;

    applyStimulus(3'd0, 32'd3, 32'd3, res, lat, vcnt, ebad);
    checkOutput("post_rst_mul_result", 64'(res), 64'd9);
    checkOutput("post_rst_mul_latency", 64'(lat), 64'd37);
    checkOutput("post_rst_mul_en_window", 64'(ebad), 64'd0);

    // Random scoreboard with corner-weighted operands
    for (int n = 0; n < 150; n++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = pick_operand();
      rb = pick_operand();
      applyStimulus(ro, ra, rb, res, lat, vcnt, ebad);
      tag = $sformatf("rand%0d_op%0d_a%0h_b%0h", n, ro, ra, rb);
      checkOutput({tag, "_result"}, 64'(res), 64'(ref_model(ro, ra, rb)));
      checkOutput({tag, "_latency"}, 64'(lat), 64'd37);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
